// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, instruction queue; optional trap macro FETCH_MISALIGN_TRAP_EN
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_rd_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam int            PW      = (QUEUE_DEPTH > 2) ? 2 : 1;
   localparam int            CW      = PW + 1;
   localparam logic [31:0]   NOP     = 32'h0000_0013;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic          inflight_q, inflight_d;
   logic          discard_q, discard_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   last_pc_q, last_pc_d;
   logic [31:0]   word_q [QUEUE_DEPTH];
   logic [31:0]   wpc_q  [QUEUE_DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic          halt;
   logic [CW-1:0] occ;
   logic [31:0]   target;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   assign halt        = fault_q;
   assign fetch_fault = fault_q;
`else
   assign halt        = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   assign imem_addr  = pc_q;
   assign imem_rd_en = issue;

   // Queue head presentation; an empty queue shows a NOP and the last head PC
   always_comb begin
      instr_valid = (count_q != '0);
      instr       = NOP;
      instr_pc    = last_pc_q;
      if (count_q != '0) begin
         instr    = word_q[rd_ptr_q];
         instr_pc = wpc_q[rd_ptr_q];
      end
   end

   // Issue decision, response push, queue pointers and PC next state
   always_comb begin
      pop        = instr_valid & instr_ready;
      push       = inflight_q & ~discard_q & ~redirect;
      // occupancy after this edge; the issue reserves one slot for its response
      occ        = count_q + CW'(inflight_q) - CW'(pop);
      issue      = rst_n & ~redirect & ~halt & (occ < DEPTH_C);

      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = issue;
      discard_d  = redirect & inflight_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      last_pc_d  = instr_pc;
      target     = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d    = fault_q;
      if (redirect) begin
         if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            target  = redirect_pc;
         end else begin
            fault_d = 1'b0;
         end
      end
`endif

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end

      if (redirect) begin
         pc_d = target;
      end else if (issue) begin
         pc_d      = pc_q + 32'd4;
         resp_pc_d = pc_q;
      end
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         last_pc_q  <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         last_pc_q  <= last_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q    <= fault_d;
`endif
      end
   end

   // Queue storage; entries beyond count are never observed so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr_q] <= imem_rdata;
         wpc_q[wr_ptr_q]  <= resp_pc_q;
      end
   end

   // The issue rule must make a push into a full queue impossible
   always_ff @(posedge clk) begin
      if (rst_n && push && !pop) begin
         assert (count_q < DEPTH_C);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a stream-level model
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] KEY      = 32'h5A5A_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   logic [31:0] exp_pop_pc;
   logic [31:0] exp_req_pc;
   logic [31:0] last_seen;
   logic        exp_fault;
   logic [31:0] held_pc;
   logic        r_rst, r_rdy, r_rd;
   logic [31:0] r_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_rd_en  (imem_rd_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   // synchronous memory: data one cycle after a request, garbage otherwise
   always @(posedge clk) begin
      imem_rdata <= imem_rd_en ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tgt(input logic [31:0] rpc);
`ifdef FETCH_MISALIGN_TRAP_EN
      return rpc;
`else
      return rpc & 32'hFFFF_FFFC;
`endif
   endfunction

   // one cycle: drive at negedge, sample 1ns later, update the stream model
   task automatic step(input logic rstn_v, input logic rdy, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      rst_n       = rstn_v;
      instr_ready = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      if (!rstn_v) begin
         chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
         exp_pop_pc = RESET_PC;
         exp_req_pc = RESET_PC;
         exp_fault  = 1'b0;
         last_seen  = RESET_PC;
      end else begin
         chk("fault", 32'(fetch_fault), 32'(exp_fault));
         chk("addr_is_pc", imem_addr, exp_req_pc);
         if (instr_valid) begin
            last_seen = instr_pc;
         end else begin
            chk("empty_nop", instr, NOP);
            chk("empty_pc_hold", instr_pc, last_seen);
         end
         if (instr_valid && rdy) begin
            chk("pop_pc", instr_pc, exp_pop_pc);
            chk("pop_instr", instr, exp_pop_pc ^ KEY);
            exp_pop_pc = exp_pop_pc + 32'd4;
            pops++;
         end
         if (rd || exp_fault) chk("no_issue", 32'(imem_rd_en), 32'd0);
         if (imem_rd_en) exp_req_pc = exp_req_pc + 32'd4;
         if (rd) begin
            exp_req_pc = tgt(rpc);
            exp_pop_pc = tgt(rpc);
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_fault  = (rpc[1:0] != 2'b00);
`endif
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      exp_pop_pc = RESET_PC; exp_req_pc = RESET_PC; exp_fault = 1'b0; last_seen = RESET_PC;

      // reset state
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, RESET_PC);
      chk("rst_fault", 32'(fetch_fault), 32'd0);

      // release latency and sustained throughput
      step(1, 1, 0, 0);
      chk("c0_rd_en", 32'(imem_rd_en), 32'd1);
      chk("c0_addr", imem_addr, RESET_PC);
      chk("c0_valid", 32'(instr_valid), 32'd0);
      step(1, 1, 0, 0);
      chk("c1_valid", 32'(instr_valid), 32'd0);
      step(1, 1, 0, 0);
      chk("c2_valid", 32'(instr_valid), 32'd1);
      chk("c2_pc", instr_pc, RESET_PC);
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, 0);
         chk("stream_valid", 32'(instr_valid), 32'd1);
      end

      // backpressure: head stable, requests stop, release without loss
      step(1, 0, 0, 0);
      held_pc = instr_pc;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0);
         chk("hold_pc", instr_pc, held_pc);
         chk("hold_valid", 32'(instr_valid), 32'd1);
      end
      chk("hold_no_req", 32'(imem_rd_en), 32'd0);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

      // redirect while a response is in flight
      step(1, 1, 1, 32'h0000_1000);
      step(1, 1, 0, 0);
      chk("rd_gap1", 32'(instr_valid), 32'd0);
      step(1, 1, 0, 0);
      chk("rd_gap2", 32'(instr_valid), 32'd0);
      step(1, 1, 0, 0);
      chk("rd_first_valid", 32'(instr_valid), 32'd1);
      chk("rd_first_pc", instr_pc, 32'h0000_1000);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

      // PC wrap-around
      step(1, 1, 1, 32'hFFFF_FFF8);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
      step(1, 1, 0, 0);
      chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
      step(1, 1, 0, 0);
      chk("wrap_pc2", instr_pc, 32'h0000_0000);

      // misaligned target
      step(1, 1, 1, 32'h0000_1002);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      chk("mis_no_req", 32'(imem_rd_en), 32'd0);
      chk("mis_empty", 32'(instr_valid), 32'd0);
      step(1, 1, 1, 32'h0000_2000);
      step(1, 1, 0, 0);
      chk("mis_clear", 32'(fetch_fault), 32'd0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("mis_resume_pc", instr_pc, 32'h0000_2000);
`else
      chk("mis_forced_pc", instr_pc, 32'h0000_1000);
      chk("mis_no_fault", 32'(fetch_fault), 32'd0);
`endif

      // back-to-back redirects: last wins
      step(1, 1, 1, 32'h0000_3000);
      step(1, 1, 1, 32'h0000_4000);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("b2b_valid", 32'(instr_valid), 32'd1);
      chk("b2b_pc", instr_pc, 32'h0000_4000);

      // mid-stream reset with a full queue
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      chk("mrst_valid", 32'(instr_valid), 32'd0);
      chk("mrst_instr", instr, NOP);
      chk("mrst_addr", imem_addr, RESET_PC);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("mrst_first_pc", instr_pc, RESET_PC);

      // randomized traffic against the stream model
      for (int i = 0; i < 800; i++) begin
         r_rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rd  = ($urandom_range(0, 24) == 0);
         r_pc  = $urandom;
         if ($urandom_range(0, 3) != 0) r_pc = r_pc & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
         step(r_rst, r_rdy, r_rd, r_pc);
      end
      chk("liveness", 32'(pops > 150), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
